// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite RAM responder.
package axi4lite_pkg;

  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    W_NEED_DATA,
    W_NEED_ADDR,
    B_WAIT,
    B_RESP,
    R_WAIT,
    R_RESP
  } axi_state_t;

endpackage

// File: rtl/axi4lite_ram_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module axi4lite_ram_array
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [STRB_W-1:0]    wr_en,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_BITS];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (wr_en[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi4lite_ram_slave.sv
// AXI4-Lite RAM responder: one transaction at a time, writes win over reads.
// Define AXI_SLAVE_WAIT_EN to insert WAIT_CYCLES extra response cycles.
module axi4lite_ram_slave
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       AWdata,
  input  logic              AWvalid,
  output logic              AWready,
  input  logic [2:0]        AWprot,
  input  logic [31:0]       Wdata,
  input  logic [3:0]        Wstrb,
  input  logic              Wvalid,
  output logic              Wready,
  output logic              Bvalid,
  input  logic              Bready,
  input  logic [31:0]       ARdata,
  input  logic              ARvalid,
  output logic              ARready,
  input  logic [2:0]        ARprot,
  output logic [31:0]       Rdata,
  output logic              Rvalid,
  input  logic              RReady
);

  axi_state_t state, state_nx, b_next, r_next;
  logic [ADDR_BITS-1:0] addr_q, ram_addr;
  logic [DATA_W-1:0]    wdata_q, ram_wdata;
  logic [STRB_W-1:0]    strb_q, ram_we;
  logic lat_aw, lat_w, lat_ar, wr_done, rd_accept, ram_rd, wait_done;
  logic aw_hs, w_hs, ar_hs;
  logic unused_bits;

  function automatic logic [ADDR_BITS-1:0] word_idx(input logic [31:0] a);
    return a[ADDR_BITS+ADDR_LSB-1:ADDR_LSB];
  endfunction

  assign unused_bits = ^{AWprot, ARprot, AWdata, ARdata, 8'(WAIT_CYCLES)};

  assign AWready = ~rst & ((state == IDLE) | (state == W_NEED_ADDR));
  assign Wready  = ~rst & ((state == IDLE) | (state == W_NEED_DATA));
  assign ARready = ~rst & (state == IDLE) & ~AWvalid & ~Wvalid;
  assign Bvalid  = (state == B_RESP);
  assign Rvalid  = (state == R_RESP);

  assign aw_hs = AWvalid & AWready;
  assign w_hs  = Wvalid & Wready;
  assign ar_hs = ARvalid & ARready;

`ifdef AXI_SLAVE_WAIT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       wait_cnt <= '0;
    else if (wr_done || rd_accept) wait_cnt <= 8'(WAIT_CYCLES);
    else if (wait_cnt != '0)       wait_cnt <= wait_cnt - 8'd1;
  end

  // Leave the wait state on the edge that takes the counter to zero.
  assign wait_done = (wait_cnt <= 8'd1);
  assign b_next    = (WAIT_CYCLES != 0) ? B_WAIT : B_RESP;
  assign r_next    = (WAIT_CYCLES != 0) ? R_WAIT : R_RESP;
`else
  assign wait_done = 1'b1;
  assign b_next    = B_RESP;
  assign r_next    = R_RESP;
`endif

  always_comb begin
    state_nx  = state;
    lat_aw    = 1'b0;
    lat_w     = 1'b0;
    lat_ar    = 1'b0;
    wr_done   = 1'b0;
    rd_accept = 1'b0;
    ram_rd    = 1'b0;
    ram_we    = '0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    case (state)
      IDLE: begin
        if (aw_hs && w_hs) begin
          ram_addr  = word_idx(AWdata);
          ram_wdata = Wdata;
          ram_we    = Wstrb;
          wr_done   = 1'b1;
          state_nx  = b_next;
        end else if (aw_hs) begin
          lat_aw   = 1'b1;
          state_nx = W_NEED_DATA;
        end else if (w_hs) begin
          lat_w    = 1'b1;
          state_nx = W_NEED_ADDR;
        end else if (ar_hs) begin
          lat_ar    = 1'b1;
          rd_accept = 1'b1;
          state_nx  = r_next;
          if (r_next == R_RESP) begin
            ram_rd   = 1'b1;
            ram_addr = word_idx(ARdata);
          end
        end
      end
      W_NEED_DATA: if (w_hs) begin
        ram_wdata = Wdata;
        ram_we    = Wstrb;
        wr_done   = 1'b1;
        state_nx  = b_next;
      end
      W_NEED_ADDR: if (aw_hs) begin
        ram_addr = word_idx(AWdata);
        ram_we   = strb_q;
        wr_done  = 1'b1;
        state_nx = b_next;
      end
      B_WAIT: if (wait_done) state_nx = B_RESP;
      B_RESP: if (Bready) state_nx = IDLE;
      R_WAIT: if (wait_done) begin
        ram_rd   = 1'b1;
        state_nx = R_RESP;
      end
      R_RESP: if (RReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state <= state_nx;
      if (lat_aw)      addr_q <= word_idx(AWdata);
      else if (lat_ar) addr_q <= word_idx(ARdata);
      if (lat_w) begin
        wdata_q <= Wdata;
        strb_q  <= Wstrb;
      end
    end
  end

  axi4lite_ram_array #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .rd_en (ram_rd),
    .wr_en (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (Rdata)
  );

endmodule

// File: tb/tb_axi4lite_ram_slave.sv
// Scoreboard bench for axi4lite_ram_slave; read data and write responses are
// queued at request time and retired by a negedge monitor on each handshake.
module tb_axi4lite_ram_slave;

  localparam int unsigned AB = 10;
`ifdef AXI_SLAVE_WAIT_EN
  localparam int unsigned WAIT = 3;
`else
  localparam int unsigned WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AWdata, Wdata, ARdata, Rdata;
  logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
  logic        ARvalid, ARready, Rvalid, RReady;
  logic [3:0]  Wstrb;
  logic [2:0]  AWprot = 3'b000;
  logic [2:0]  ARprot = 3'b010;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] model [1<<AB];
  logic [31:0] exp_r_q [$];
  int          exp_b_q [$];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  axi4lite_ram_slave #(.ADDR_BITS(AB), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst),
    .AWdata(AWdata), .AWvalid(AWvalid), .AWready(AWready), .AWprot(AWprot),
    .Wdata(Wdata), .Wstrb(Wstrb), .Wvalid(Wvalid), .Wready(Wready),
    .Bvalid(Bvalid), .Bready(Bready),
    .ARdata(ARdata), .ARvalid(ARvalid), .ARready(ARready), .ARprot(ARprot),
    .Rdata(Rdata), .Rvalid(Rvalid), .RReady(RReady)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[a[AB+1:2]][8*i +: 8] = d[8*i +: 8];
  endfunction

  always @(negedge clk) begin
    if (!rst && Bvalid && Bready) begin
      check("b_expected", 32'(exp_b_q.size() != 0), 32'd1);
      if (exp_b_q.size() != 0) void'(exp_b_q.pop_front());
    end
    if (!rst && Rvalid && RReady) begin
      if (exp_r_q.size() == 0) check("r_expected", 32'd0, 32'd1);
      else                     check("rdata", Rdata, exp_r_q.pop_front());
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int hold);
    bit aw_done = 0, w_done = 0, aw_hit, w_hit;
    int cyc = 0, lat = 0;
    AWdata = a; Wdata = d; Wstrb = s; Bready = (hold == 0);
    while (!(aw_done && w_done) && cyc < 50) begin
      AWvalid = !aw_done && (cyc >= aw_dly);
      Wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      if (w_done && !aw_done) begin
        check("awready_w_held", AWready, 1);
        check("wready_w_held", Wready, 0);
      end
      if (aw_done && !w_done) begin
        check("wready_aw_held", Wready, 1);
        check("awready_aw_held", AWready, 0);
      end
      aw_hit = AWvalid && AWready;
      w_hit  = Wvalid && Wready;
      @(posedge clk); #1;
      aw_done |= aw_hit;
      w_done  |= w_hit;
      cyc++;
    end
    AWvalid = 0; Wvalid = 0;
    if (!(aw_done && w_done)) begin
      check("write_timeout", 32'd0, 32'd1);
      return;
    end
    model_write(a, d, s);
    exp_b_q.push_back(1);
    do begin @(negedge clk); lat++; end while (!Bvalid && lat < 40);
    check("b_latency", lat, 1 + WAIT);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("bvalid_hold", Bvalid, 1);
        check("ready_in_b_hold", {AWready, Wready, ARready}, 0);
      end
      @(posedge clk); #1;
      Bready = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    bit hit = 0;
    int cyc = 0, lat = 0;
    logic [31:0] e;
    ARdata = a; RReady = (hold == 0);
    while (!hit && cyc < 50) begin
      ARvalid = 1;
      @(negedge clk);
      hit = ARvalid && ARready;
      @(posedge clk); #1;
      cyc++;
    end
    ARvalid = 0;
    if (!hit) begin
      check("read_timeout", 32'd0, 32'd1);
      return;
    end
    e = model[a[AB+1:2]];
    exp_r_q.push_back(e);
    do begin @(negedge clk); lat++; end while (!Rvalid && lat < 40);
    check("r_latency", lat, 1 + WAIT);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("rvalid_hold", Rvalid, 1);
        check("rdata_hold", Rdata, e);
        check("ready_in_r_hold", {AWready, Wready, ARready}, 0);
      end
      @(posedge clk); #1;
      RReady = 1;
    end
    @(posedge clk); #1;
    last_rd = e;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rd;
    rst = 1; AWvalid = 0; Wvalid = 0; ARvalid = 0; Bready = 1; RReady = 1;
    AWdata = '0; Wdata = '0; Wstrb = '0; ARdata = '0; last_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readies", {AWready, Wready, ARready}, 0);
    check("rst_valids", {Bvalid, Rvalid}, 0);
    check("rst_rdata", Rdata, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("idle_readies", {AWready, Wready, ARready}, 3'b111);
    @(posedge clk); #1;

    // full write, W-first partial write, AW-first write
    do_write(32'h10, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
    do_read(32'h10, 0);
    do_write(32'h10, 32'h000000AA, 4'b0001, 3, 0, 0);
    do_read(32'h10, 0);
    check("partial_lane", last_rd, 32'hDEADBEAA);
    do_write(32'h14, 32'h55667788, 4'b1111, 0, 2, 0);
    do_read(32'h14, 0);

    // simultaneous AR and AW/W: write must win
    AWdata = 32'h20; Wdata = 32'h12345678; Wstrb = 4'hF; ARdata = 32'h20;
    AWvalid = 1; Wvalid = 1; ARvalid = 1;
    @(negedge clk);
    check("ar_blocked", ARready, 0);
    check("aw_w_taken", {AWready, Wready}, 2'b11);
    @(posedge clk); #1;
    AWvalid = 0; Wvalid = 0;
    model_write(32'h20, 32'h12345678, 4'hF);
    exp_b_q.push_back(1);
    do_read(32'h20, 0);
    check("prio_read", last_rd, 32'h12345678);

    // backpressure on both response channels
    do_write(32'h30, 32'hCAFEF00D, 4'b1111, 0, 0, 5);
    do_read(32'h30, 5);

    // reset while waiting for write data
    AWdata = 32'h10; AWvalid = 1;
    @(negedge clk);
    check("aw_accept_pre_rst", AWready, 1);
    @(posedge clk); #1;
    AWvalid = 0;
    @(negedge clk);
    check("w_need_data_wready", {AWready, Wready}, 2'b01);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("mid_rst_readies", {AWready, Wready, ARready}, 0);
    check("mid_rst_rdata", Rdata, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_bvalid_after_rst", {Bvalid, AWready}, 2'b01);
      @(posedge clk); #1;
    end
    do_read(32'h10, 0);
    check("no_partial_write", last_rd, 32'hDEADBEAA);

    // null strobe, then aliased address with low bits set
    do_write(32'h10, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
    do_read(32'h1013, 0);
    check("alias_null_strb", last_rd, 32'hDEADBEAA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rdata_keep", Rdata, 32'hDEADBEAA);
    end
    @(posedge clk); #1;

    // randomised traffic over a small window
    for (int i = 0; i < 8; i++) do_write(32'h40 + 32'(4*i), $urandom, 4'hF, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      ra = 32'h40 + 32'(4 * $urandom_range(0, 7));
      rd = $urandom;
      if ($urandom_range(0, 1) == 0)
        do_write(ra, rd, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2));
      else
        do_read(ra, $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    #1;
    check("r_queue_drained", exp_r_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
